// File: rtl/dmem_access_unit.sv
// dmem_access_unit: initiator side of a word-indexed data memory port.
// Turns byte/halfword/word loads and stores from the MEM stage into word
// reads, word writes, or read-modify-write sequences, and returns aligned,
// extended load data with a one-cycle response pulse.
// Optional build macro DMEM_RANGE_CHECK_EN: when defined, a request whose
// byte address lies beyond the memory depth faults instead of wrapping.
module dmem_access_unit #(
   parameter int DEPTH_W = 5,
   parameter int RD_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   // Counter value on the last cycle of the read wait window.
   localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);

   state_t      state;
   logic [3:0]  rd_cnt;
   logic        write_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [1:0]  off_q;
   logic [15:0] wdata_q;   // only the lanes a sub-word store can touch

   logic        req_err;
   logic [31:0] req_index;

`ifndef DMEM_RANGE_CHECK_EN
   // Upper address bits wrap silently in this build.
   logic unused_upper_addr;
   assign unused_upper_addr = ^req_addr_i[31:DEPTH_W+2];
`endif

   assign req_ready_o = (state == IDLE) && !rst_i;
   assign req_index   = 32'(req_addr_i[DEPTH_W+1:2]);

   // Decode request faults: illegal size, misalignment, optional range.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      req_err = 1'b0;
      case (req_size_i)
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = req_addr_i[0];
         SZ_WORD: req_err = |req_addr_i[1:0];
         default: req_err = 1'b1;
      endcase
`ifdef DMEM_RANGE_CHECK_EN
      if (|req_addr_i[31:DEPTH_W+2]) req_err = 1'b1;
`endif
   end

   // Select the addressed lane of a word and zero- or sign-extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: return sgn ? {{24{b[7]}}, b} : {24'd0, b};
         SZ_HALF: return sgn ? {{16{h[15]}}, h} : {16'd0, h};
         default: return word;
      endcase
   endfunction

   // Replace the addressed byte or halfword lane of a word with store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [15:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
      logic [31:0] res;
      res = word;
      if (size == SZ_BYTE) begin
         case (off)
            2'd0:    res[7:0]   = wdata[7:0];
            2'd1:    res[15:8]  = wdata[7:0];
            2'd2:    res[23:16] = wdata[7:0];
            default: res[31:24] = wdata[7:0];
         endcase
      end else if (off[1]) begin
         res[31:16] = wdata;
      end else begin
         res[15:0] = wdata;
      end
      return res;
   endfunction

   // Sequencer: accept, read wait window, write, respond; all outputs registered.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         state        <= IDLE;
         rd_cnt       <= 4'd0;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         off_q        <= 2'b00;
         wdata_q      <= 16'd0;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= 32'd0;
         resp_err_o   <= 1'b0;
         mem_addr_o   <= 32'd0;
         mem_wdata_o  <= 32'd0;
         mem_read_o   <= 1'b0;
         mem_write_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  write_q  <= req_write_i;
                  size_q   <= req_size_i;
                  signed_q <= req_signed_i;
                  off_q    <= req_addr_i[1:0];
                  wdata_q  <= req_wdata_i[15:0];
                  if (req_err) begin
                     state        <= RESP;
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                     resp_rdata_o <= 32'd0;
                  end else if (!req_write_i || req_size_i != SZ_WORD) begin
                     state      <= RD;
                     rd_cnt     <= 4'd0;
                     mem_addr_o <= req_index;
                     mem_read_o <= 1'b1;
                  end else begin
                     state       <= WR;
                     mem_addr_o  <= req_index;
                     mem_wdata_o <= req_wdata_i;
                     mem_write_o <= 1'b1;
                  end
               end
            end
            RD: begin
               if (rd_cnt == RD_LAST) begin
                  mem_read_o <= 1'b0;
                  if (write_q) begin
                     state       <= WR;
                     mem_wdata_o <= store_merge(mem_rdata_i, wdata_q, size_q, off_q);
                     mem_write_o <= 1'b1;
                  end else begin
                     state        <= RESP;
                     resp_valid_o <= 1'b1;
                     resp_rdata_o <= load_extend(mem_rdata_i, size_q, off_q, signed_q);
                  end
               end else begin
                  rd_cnt <= rd_cnt + 4'd1;
               end
            end
            WR: begin
               mem_write_o  <= 1'b0;
               state        <= RESP;
               resp_valid_o <= 1'b1;
               resp_rdata_o <= 32'd0;
            end
            default: begin
               resp_valid_o <= 1'b0;
               resp_err_o   <= 1'b0;
               resp_rdata_o <= 32'd0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: randomized self-checking bench for dmem_access_unit.
// A word array behind the memory port plays the memory; a separate reference
// array models the architectural memory contents and load results.
module tb_dmem_access_unit;

   localparam int DEPTH_W = 5;
   localparam int RD_WAIT = 2;
   localparam int NWORDS  = 1 << DEPTH_W;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [1:0]  req_size_i;
   logic        req_signed_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [31:0] mem_rdata_i;

   logic [31:0] tb_mem  [NWORDS];
   logic [31:0] ref_mem [NWORDS];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_access_unit #(.DEPTH_W(DEPTH_W), .RD_WAIT(RD_WAIT)) dut (
      .clk          (clk),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_write_i  (req_write_i),
      .req_size_i   (req_size_i),
      .req_signed_i (req_signed_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .resp_valid_o (resp_valid_o),
      .resp_rdata_o (resp_rdata_o),
      .resp_err_o   (resp_err_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_read_o   (mem_read_o),
      .mem_write_o  (mem_write_o),
      .mem_rdata_i  (mem_rdata_i)
   );

   // Memory behind the port: combinational read, write on the clock edge.
   assign mem_rdata_i = tb_mem[mem_addr_o[DEPTH_W-1:0]];
   always @(posedge clk) if (mem_write_o) tb_mem[mem_addr_o[DEPTH_W-1:0]] <= mem_wdata_o;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic preset(input int idx, input logic [31:0] val);
      tb_mem[idx]  = val;
      ref_mem[idx] = val;
   endtask

   // Issue one request, follow it to its response, compare against the model.
   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd_out, output logic err_out,
                         output logic [31:0] wdata_seen);
      int          idx, off, nbytes, exp_lat, exp_reads, exp_writes;
      int          lat, reads, writes, waits, both;
      logic        exp_err;
      logic [31:0] mask, old, lane, exp_rd, exp_new, read_addr, write_addr;

      idx     = int'(a[DEPTH_W+1:2]);
      off     = int'(a[1:0]);
      exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`ifdef DMEM_RANGE_CHECK_EN
      if ((a >> (DEPTH_W + 2)) != 0) exp_err = 1'b1;
`endif
      nbytes  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      mask    = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      old     = ref_mem[idx];
      exp_rd  = 32'd0;
      exp_new = old;
      if (!exp_err && !wr) begin
         lane = (old >> (8 * off)) & mask;
         if (sg && nbytes < 4 && ((lane >> (8 * nbytes - 1)) & 32'd1) == 32'd1) lane = lane | ~mask;
         exp_rd = lane;
      end
      if (!exp_err && wr) exp_new = (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      if (exp_err)           begin exp_lat = 1;           exp_reads = 0;       exp_writes = 0; end
      else if (!wr)          begin exp_lat = RD_WAIT + 1; exp_reads = RD_WAIT; exp_writes = 0; end
      else if (sz == 2'b10)  begin exp_lat = 2;           exp_reads = 0;       exp_writes = 1; end
      else                   begin exp_lat = RD_WAIT + 2; exp_reads = RD_WAIT; exp_writes = 1; end

      @(negedge clk);
      req_valid_i  = 1'b1;
      req_write_i  = wr;
      req_size_i   = sz;
      req_signed_i = sg;
      req_addr_i   = a;
      req_wdata_i  = wd;
      waits = 0;
      while (!req_ready_o && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      check("ready_before_accept", {31'd0, req_ready_o}, 32'd1);
      @(posedge clk);
      #1;
      // Scramble the request bus to show the unit latched it.
      req_valid_i  = 1'b0;
      req_write_i  = 1'($urandom);
      req_size_i   = 2'($urandom);
      req_signed_i = 1'($urandom);
      req_addr_i   = $urandom;
      req_wdata_i  = $urandom;

      lat = 0; reads = 0; writes = 0; both = 0;
      read_addr = 32'd0; write_addr = 32'd0; wdata_seen = 32'd0;
      rd_out = 32'd0; err_out = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (mem_read_o && mem_write_o) both++;
         if (mem_read_o)  begin reads++;  read_addr = mem_addr_o; end
         if (mem_write_o) begin writes++; write_addr = mem_addr_o; wdata_seen = mem_wdata_o; end
         if (resp_valid_o) begin
            lat     = c;
            rd_out  = resp_rdata_o;
            err_out = resp_err_o;
            break;
         end
      end
      check("resp_latency", lat, exp_lat);
      check("resp_err", {31'd0, err_out}, {31'd0, exp_err});
      check("resp_rdata", rd_out, exp_rd);
      check("read_cycles", reads, exp_reads);
      check("write_cycles", writes, exp_writes);
      check("enables_exclusive", both, 0);
      if (exp_reads > 0)  check("read_addr", read_addr, idx);
      if (exp_writes > 0) begin
         check("write_addr", write_addr, idx);
         check("write_data", wdata_seen, exp_new);
      end
      @(negedge clk);
      check("resp_one_cycle", {31'd0, resp_valid_o}, 32'd0);
      check("idle_enables", {30'd0, mem_read_o, mem_write_o}, 32'd0);
      ref_mem[idx] = exp_new;
   endtask

   logic [31:0] rd, wseen;
   logic        er;

   initial begin
      rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'b00;
      req_signed_i = 1'b0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
      for (int i = 0; i < NWORDS; i++) preset(i, $urandom);
      repeat (3) @(negedge clk);
      check("reset_ready", {31'd0, req_ready_o}, 32'd0);
      check("reset_resp", {resp_valid_o, resp_err_o, 30'd0}, 32'd0);
      check("reset_rdata", resp_rdata_o, 32'd0);
      check("reset_addr", mem_addr_o, 32'd0);
      check("reset_enables", {30'd0, mem_read_o, mem_write_o}, 32'd0);
      rst_i = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {31'd0, req_ready_o}, 32'd1);

      // Word store then word load.
      do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, rd, er, wseen);
      check("word_store_wdata", wseen, 32'hDEAD_BEEF);
      do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, rd, er, wseen);
      check("word_load_data", rd, 32'hDEAD_BEEF);

      // Byte store read-modify-write.
      preset(2, 32'h1122_3344);
      do_req(1'b1, 2'b00, 1'b0, 32'hA, 32'h0000_00AB, rd, er, wseen);
      check("rmw_wdata", wseen, 32'h11AB_3344);

      // Sign and zero extension.
      preset(3, 32'h8001_FF80);
      do_req(1'b0, 2'b00, 1'b1, 32'hC, 32'd0, rd, er, wseen);
      check("byte_signed", rd, 32'hFFFF_FF80);
      do_req(1'b0, 2'b01, 1'b0, 32'hE, 32'd0, rd, er, wseen);
      check("half_unsigned", rd, 32'h0000_8001);
      do_req(1'b0, 2'b01, 1'b1, 32'hE, 32'd0, rd, er, wseen);
      check("half_signed", rd, 32'hFFFF_8001);

      // Misaligned and illegal sizes.
      do_req(1'b0, 2'b01, 1'b0, 32'h5, 32'd0, rd, er, wseen);
      check("err_half_misaligned", {31'd0, er}, 32'd1);
      do_req(1'b1, 2'b10, 1'b0, 32'h6, 32'h1234_5678, rd, er, wseen);
      check("err_word_misaligned", {31'd0, er}, 32'd1);
      do_req(1'b0, 2'b11, 1'b0, 32'h4, 32'd0, rd, er, wseen);
      check("err_size11", {31'd0, er}, 32'd1);

      // Address beyond the memory depth.
      preset(0, 32'hCAFE_0000);
      do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'd0, rd, er, wseen);
`ifdef DMEM_RANGE_CHECK_EN
      check("range_err", {31'd0, er}, 32'd1);
`else
      check("range_wrap", rd, 32'hCAFE_0000);
`endif

      // Reset during the read phase of a byte store.
      preset(5, 32'h5566_7788);
      @(negedge clk);
      req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'b00; req_signed_i = 1'b0;
      req_addr_i = 32'h15; req_wdata_i = 32'h0000_00CC;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      @(negedge clk);
      check("rmw_in_read", {31'd0, mem_read_o}, 32'd1);
      rst_i = 1'b1;
      @(negedge clk);
      check("abort_enables", {30'd0, mem_read_o, mem_write_o}, 32'd0);
      check("abort_no_resp", {31'd0, resp_valid_o}, 32'd0);
      check("abort_ready_in_reset", {31'd0, req_ready_o}, 32'd0);
      rst_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort_quiet", {29'd0, resp_valid_o, mem_read_o, mem_write_o}, 32'd0);
      end
      check("abort_ready", {31'd0, req_ready_o}, 32'd1);
      check("abort_mem_intact", tb_mem[5], 32'h5566_7788);

      // Randomized traffic.
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         sz = 2'($urandom_range(0, 3));
         a  = $urandom & 32'h7F;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
         end
         if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FF80) | 32'h100;
         do_req(1'($urandom), sz, 1'($urandom), a, $urandom, rd, er, wseen);
      end

      // Memory contents must match the reference model.
      for (int i = 0; i < NWORDS; i++) check("final_mem", tb_mem[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator side of the word-indexed data memory interface (addr, write data, MemRead, MemWrite, read data).
- Accepts byte, halfword and word load/store requests from the CPU MEM stage.
- Converts each request into word accesses: read, write, or read-modify-write for sub-word stores.
- Returns aligned, extended load data with a single-cycle response pulse; the pipeline stalls on req_ready_o.

Parameters:
- DEPTH_W, 5, log2 of memory depth in words; word index = req_addr_i[DEPTH_W+1:2].
- RD_WAIT, 1, cycles mem_read_o is held before mem_rdata_i is captured (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit idle; request accepted when valid&ready
- req_write_i  in  1  1=store, 0=load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed_i  in  1  sign-extend sub-word loads
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-justified
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  32  load result; 0 for stores and errors
- resp_err_o  out  1  request faulted (valid with resp_valid_o)
- mem_addr_o  out  32  word index to memory, zero-extended
- mem_wdata_o  out  32  word to write
- mem_read_o  out  1  memory read enable
- mem_write_o  out  1  memory write enable
- mem_rdata_i  in  32  memory read data

Behaviour:
- Reset: all registered outputs are 0 and state is IDLE.
- req_ready_o = (state==IDLE) & ~rst_i.
- FSM states: IDLE, RD, WR, RESP.
- Requests are latched on acceptance, so inputs may change afterwards.
- IDLE:
  - Error if size==11, size==01 with addr[0]!=0, or size==10 with addr[1:0]!=0 → RESP with err=1. No memory enable is asserted.
  - Load, or store with size!=10 → RD.
  - Word store → WR.
- RD:
  - mem_read_o=1 and mem_addr_o=index for exactly RD_WAIT cycles; a 4-bit counter tracks them.
  - mem_rdata_i is captured on the final RD cycle edge.
  - Load → RESP. Sub-word store → WR.
- WR:
  - mem_write_o=1 for exactly one cycle.
  - mem_wdata_o = req_wdata_i for a word store.
  - For a sub-word store, mem_wdata_o = captured word with the addressed lane replaced.
  - Little-endian lanes: byte k = bits [8k+7:8k]; halfword at addr[1] = bits [16*addr[1]+15:16*addr[1]].
  - Then → RESP.
- RESP: resp_valid_o=1 for one cycle, then → IDLE. There is no response backpressure.
- mem_read_o and mem_write_o are never both 1.
- Both enables are 0 in IDLE and RESP.
- mem_addr_o holds its last value when idle.
- Load data:
  - Lane selected by addr[1:0].
  - Byte/half are zero-extended, or sign-extended when req_signed_i=1.
  - Word loads pass through unchanged.
- Latency from the accept edge to resp_valid_o:
  - Load: RD_WAIT+1 cycles.
  - Word store: 2 cycles.
  - Sub-word store: RD_WAIT+2 cycles.
  - Error: 1 cycle.
- Back-to-back operation: the next request is accepted in the IDLE cycle after RESP.
- req_valid_i while busy is ignored; the source holds it.
- Reset mid-operation: the FSM aborts to IDLE on the next edge. Enables drop, no response is issued, and a partial RMW never writes.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined: req_addr_i[31:DEPTH_W+2] != 0 is an error (RESP, err=1, no memory access), checked in IDLE together with alignment.
- Undefined: upper address bits are ignored and the index wraps modulo 2^DEPTH_W.

Test Plan:
- Word store, then word load:
  - Store addr=0x0000_0008, wdata=0xDEADBEEF → mem_write_o one cycle, mem_addr_o=2, mem_wdata_o=0xDEADBEEF, resp 2 cycles after accept.
  - Load 0x8 → resp_rdata_o=0xDEADBEEF, err=0, resp RD_WAIT+1 cycles after accept.
- Byte store RMW:
  - Memory word 2 = 0x11223344; store byte addr=0xA, wdata=0x000000AB → one RD phase, then mem_wdata_o=0x11AB3344.
- Sign/zero extension:
  - Word 3 = 0x8001_FF80; load byte signed addr=0xC → 0xFFFFFF80.
  - Load half unsigned addr=0xE → 0x00008001.
- Misaligned and illegal:
  - Half at 0x5, word at 0x6, or size=11 → resp_err_o=1 one cycle after accept, rdata=0, no mem enables.
- Reset mid-RMW:
  - Assert rst_i during the RD of a byte store → no mem_write_o, no resp_valid_o, ready=1 once rst_i deasserts; memory word is unchanged.
- Range check:
  - Load addr=0x80 with DEPTH_W=5 → with DMEM_RANGE_CHECK_EN: err=1, no access; without: reads word 0.
